uart_autobaud: RTL
==================

UART_AUTOBAUD -- requirements
Module: uart_autobaud

Purpose: upstream helper for the UART core. Measures a received 0x55 sync character (8N1, LSB first) on the synchronised RX line and computes the 16-bit NCO increment the core's baud generator consumes: tick_x16 = fclk*NCO/2^16.

Interface
- REQ-001 SHALL have parameter CntW, default 24, width of the period counter and divider.
- REQ-002 SHALL have parameter TimeoutCnt, default 24'hFFFFFF, the MEASURE cycle count at which measurement aborts.
- REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
- REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
- REQ-005 SHALL have port enable_i, input, 1: block enable; low forces IDLE.
- REQ-006 SHALL have port start_i, input, 1: single-cycle pulse that arms one measurement.
- REQ-007 SHALL have port rx_i, input, 1: already-synchronised RX line, idle high.
- REQ-008 SHALL have port busy_o, output, 1: high in every state except IDLE.
- REQ-009 SHALL have port done_o, output, 1: one-cycle pulse on successful completion.
- REQ-010 SHALL have port err_o, output, 1: one-cycle pulse on failed measurement.
- REQ-011 SHALL have port nco_o, output, 16: last valid NCO increment.
- REQ-012 SHALL have port nco_valid_o, output, 1: sticky; high once any measurement has succeeded.

Function
- REQ-013 SHALL register rx_i into rx_q (reset value 1); fall = rx_q & ~rx_i; rise = ~rx_q & rx_i.
- REQ-014 SHALL implement FSM states IDLE, WAIT_FALL, MEASURE, DIVIDE, DONE.
- REQ-015 IDLE: start_i & enable_i -> WAIT_FALL; start_i in any other state SHALL be ignored.
- REQ-016 WAIT_FALL: on fall -> MEASURE, with cnt=0 and rise_cnt=0.
- REQ-017 MEASURE: cnt SHALL increment every cycle; each rise SHALL increment rise_cnt.
- REQ-018 MEASURE: on the fifth rise (detection cycle E), T=cnt+1 SHALL be latched and the FSM SHALL go to DIVIDE. T is the cycles spanning 9 bit times.
- REQ-019 MEASURE: if cnt reaches TimeoutCnt before the fifth rise, err_o SHALL pulse one cycle and the FSM SHALL go to IDLE.
- REQ-020 DIVIDE: restoring divider, one quotient bit per cycle, CntW cycles, computing Q = floor(24'h900000 / T).
- REQ-021 DIVIDE SHALL occupy cycles E+1..E+CntW; DONE SHALL be cycle E+CntW+1 (E+25 at default).
- REQ-022 DONE, if 1 <= Q <= 16'hFFFF: nco_o <= Q[15:0], nco_valid_o <= 1, done_o pulses; next state IDLE.
- REQ-023 DONE, if Q = 0 or Q > 16'hFFFF: err_o pulses, nco_o and nco_valid_o unchanged; next state IDLE.
- REQ-024 done_o and err_o SHALL never assert in the same cycle.
- REQ-025 enable_i low in any state SHALL force IDLE on the next edge; no done_o or err_o; nco_o unchanged.
- REQ-026 A rise coincident with a TimeoutCnt hit SHALL be treated as the timeout.

Reset
- REQ-027 rst_i high SHALL, on the next clk_i edge, set: state=IDLE, rx_q=1, cnt=0, rise_cnt=0, busy_o=0, done_o=0, err_o=0, nco_o=16'h0, nco_valid_o=0.
- REQ-028 Reset asserted mid-MEASURE or mid-DIVIDE SHALL abandon the operation with no done_o or err_o pulse.

Verification
- REQ-029 Reset check: assert rst_i 2 cycles -> nco_o=0, nco_valid_o=0, busy_o=0, done_o=0, err_o=0.
- REQ-030 Nominal: start_i, then 0x55 at 100 cycles/bit -> T=900, done_o at E+25, nco_o=16'h28F5, nco_valid_o=1, busy_o=0 next cycle.
- REQ-031 Too fast: 0x55 at 16 cycles/bit -> T=144, Q=65536 -> err_o pulse; nco_o keeps previous value.
- REQ-032 Timeout: TimeoutCnt=4096, send 0xD5 at 100 cycles/bit (only four rises) -> err_o at cnt=4096, FSM returns to IDLE, nco_o unchanged.
- REQ-033 Abort: enable_i low at cycle 300 of MEASURE -> busy_o=0 next cycle, no pulses; repeat with rst_i pulsed at cycle E+10 in DIVIDE -> all reset values, no pulses.
- REQ-034 Ignored start: start_i re-pulsed during MEASURE of the REQ-030 stimulus -> result and timing identical to REQ-030.

Source files
------------

// File: rtl/uart_autobaud.sv
// -----------------------------------------------------------------------------
// uart_autobaud
//
// Purpose:
//   Measures a received 0x55 sync character (8N1, LSB first) on an already
//   synchronised RX line and derives the 16-bit NCO increment used by the UART
//   core's baud generator (tick_x16 = fclk * NCO / 2^16).
//
//   Idle low on the start bit begins the measurement. 0x55 framed as 8N1
//   produces exactly five low->high transitions. The fifth one is the leading
//   edge of the stop bit, which arrives nine bit times after the start edge.
//   T (the number of cycles spanning nine bits) therefore gives
//       NCO = 2^16 * 16 / (T / 9) = 0x900000 / T
//   This value is computed with a restoring divider, one quotient bit per cycle.
//
// Parameters:
//   CntW        width of the period counter and of the divider
//   TimeoutCnt  MEASURE cycle count at which the measurement is abandoned
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_i        synchronous active-high reset
//   enable_i     block enable; low forces IDLE on the next edge
//   start_i      one-cycle pulse that arms one measurement (IDLE only)
//   rx_i         synchronised RX line, idle high
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse when a usable increment has been stored
//   err_o        one-cycle pulse on timeout or out-of-range result
//   nco_o        last valid NCO increment
//   nco_valid_o  sticky flag, set by the first successful measurement
// -----------------------------------------------------------------------------
module uart_autobaud #(
    parameter int              CntW       = 24,
    parameter logic [CntW-1:0] TimeoutCnt = 24'hFFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        start_i,
    input  logic        rx_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] nco_o,
    output logic        nco_valid_o
);

    // 2^16 * 16 * 9: converts a nine-bit span into an x16 NCO increment.
    localparam logic [CntW-1:0] Dividend  = CntW'(24'h900000);
    localparam logic [CntW-1:0] LastStep  = CntW'(CntW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FALL,
        ST_MEASURE,
        ST_DIVIDE,
        ST_DONE
    } state_t;

    state_t            state_q,     state_d;
    logic              rx_q;
    logic [CntW-1:0]   cnt_q,       cnt_d;
    logic [2:0]        rise_cnt_q,  rise_cnt_d;
    logic [CntW-1:0]   t_q,         t_d;
    logic [CntW-1:0]   rem_q,       rem_d;
    logic [CntW-1:0]   quo_q,       quo_d;
    logic [15:0]       nco_q,       nco_d;
    logic              nco_valid_q, nco_valid_d;

    logic              fall;
    logic              rise;
    logic [CntW:0]     rem_shift;
    logic              rem_ge;
    logic              quo_ok;

    assign fall = rx_q & ~rx_i;
    assign rise = ~rx_q & rx_i;

    // One restoring-division step: bring down the next dividend bit from the
    // top of the quotient shift register and try to subtract the divisor.
    assign rem_shift = {rem_q, quo_q[CntW-1]};
    assign rem_ge    = (rem_shift >= {1'b0, t_q});

    // Zero means the line was far too slow; anything above 16 bits means it
    // was too fast for the x16 generator. Neither can be programmed.
    assign quo_ok = (quo_q != '0) && (quo_q[CntW-1:16] == '0);

    assign busy_o      = (state_q != ST_IDLE);
    assign nco_o       = nco_q;
    assign nco_valid_o = nco_valid_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rise_cnt_d  = rise_cnt_q;
        t_d         = t_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        nco_d       = nco_q;
        nco_valid_d = nco_valid_q;
        done_o      = 1'b0;
        err_o       = 1'b0;

        // Reset or disable abandons whatever is in flight without reporting.
        if (rst_i || !enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_WAIT_FALL;
                    end
                end

                ST_WAIT_FALL: begin
                    if (fall) begin
                        state_d    = ST_MEASURE;
                        cnt_d      = '0;
                        rise_cnt_d = '0;
                    end
                end

                ST_MEASURE: begin
                    // Timeout is tested first so a rise on the same cycle
                    // cannot rescue the measurement.
                    if (cnt_q == TimeoutCnt) begin
                        err_o   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rise && (rise_cnt_q == 3'd4)) begin
                        // Start edge was seen one cycle before cnt=0, so the
                        // span is one more than the count.
                        t_d        = cnt_q + CntW'(1);
                        rem_d      = '0;
                        quo_d      = Dividend;
                        cnt_d      = '0;
                        rise_cnt_d = 3'd5;
                        state_d    = ST_DIVIDE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        if (rise) begin
                            rise_cnt_d = rise_cnt_q + 3'd1;
                        end
                    end
                end

                ST_DIVIDE: begin
                    // cnt is reused as the step counter; quo_q shifts the
                    // dividend out at the top and the quotient in at the bottom.
                    if (rem_ge) begin
                        rem_d = rem_shift[CntW-1:0] - t_q;
                    end else begin
                        rem_d = rem_shift[CntW-1:0];
                    end
                    quo_d = {quo_q[CntW-2:0], rem_ge};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastStep) begin
                        state_d = ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (quo_ok) begin
                        nco_d       = quo_q[15:0];
                        nco_valid_d = 1'b1;
                        done_o      = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rx_q        <= 1'b1;
            cnt_q       <= '0;
            rise_cnt_q  <= '0;
            t_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            nco_q       <= 16'h0;
            nco_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_i;
            cnt_q       <= cnt_d;
            rise_cnt_q  <= rise_cnt_d;
            t_q         <= t_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            nco_q       <= nco_d;
            nco_valid_q <= nco_valid_d;
        end
    end

endmodule
